hack_cpu_control: RTL and testbench

Multi-cycle fetch/decode/execute core that drives the combinational ALU's x/y operands and {zx,nx,zy,ny,f,no} control bits, and consumes its out/zr/ng result.
- Owns the A register, D register and PC.
- Fetches from the instruction ROM and reads/writes data RAM over separate ports (Harvard).
- Sits between instruction ROM, data RAM and the ALU; the ALU is instantiated alongside it at CPU top level, not inside it.

---
 rtl/hack_cpu_control_pkg.sv | 14 +
 rtl/hack_cpu_control_jump.sv | 9 +
 rtl/hack_cpu_control.sv | 72 +++++++
 tb/tb_hack_cpu_control.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/hack_cpu_control_pkg.sv
// hack_cpu_control_pkg: shared widths, FSM states and instruction field positions for the Hack CPU control core.
package hack_cpu_control_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int IS_C = 15;
  localparam int A_BIT = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JUMP_HI = 2;
  typedef enum logic [1:0] {FETCH, DECODE, EXEC} state_t;
endpackage

// File: rtl/hack_cpu_control_jump.sv
// hack_jump_unit: decides whether a C-instruction jump is taken from its jump bits and the ALU flags.
module hack_jump_unit (
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);
  assign take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
endmodule

// File: rtl/hack_cpu_control.sv
// hack_cpu_control: multi-cycle fetch/decode/execute control for the Hack CPU; owns A, D, PC and drives an external ALU.
module hack_cpu_control #(
  parameter int ADDR_W = hack_cpu_control_pkg::ADDR_W,
  parameter int DATA_W = hack_cpu_control_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              zx,
  output logic              nx,
  output logic              zy,
  output logic              ny,
  output logic              f,
  output logic              no,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done
);
  import hack_cpu_control_pkg::*;
  state_t state;
  logic [DATA_W-1:0] a_reg, d_reg, ir;
  logic take;
  hack_jump_unit u_jump (.jump(ir[JUMP_HI:0]), .zr(alu_zr), .ng(alu_ng), .take(take));
  assign rom_addr = pc;
  assign ram_addr = a_reg[ADDR_W-1:0];
  assign ram_wdata = alu_out;
  assign alu_x = d_reg;
  assign alu_y = ir[A_BIT] ? ram_rdata : a_reg;
  assign {zx, nx, zy, ny, f, no} = ir[COMP_HI:COMP_LO];
  // Strobes are gated by reset so an aborted instruction never writes RAM or retires.
  assign ram_we = ~reset & (state == EXEC) & ir[DEST_M];
  assign instr_done = ~reset & ((state == EXEC) | ((state == DECODE) & ~rom_data[IS_C]));
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= PC_RESET;
      a_reg <= '0;
      d_reg <= '0;
      ir <= '0;
    end else begin
      unique case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir <= rom_data;
          if (rom_data[IS_C]) state <= EXEC;
          else begin
            a_reg <= {1'b0, rom_data[DATA_W-2:0]};
            pc <= pc + 1'b1;
            state <= FETCH;
          end
        end
        EXEC: begin
          if (ir[DEST_A]) a_reg <= alu_out;
          if (ir[DEST_D]) d_reg <= alu_out;
          pc <= take ? a_reg[ADDR_W-1:0] : pc + 1'b1;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_hack_cpu_control.sv
// tb_hack_cpu_control: directed program through the control core with ROM/RAM/ALU models and hand-computed expectations.
module tb_hack_cpu_control;
  logic clk, reset;
  logic [14:0] rom_addr, ram_addr, pc;
  logic [15:0] rom_data, ram_rdata, ram_wdata, alu_x, alu_y, alu_out;
  logic ram_we, zx, nx, zy, ny, f, no, alu_zr, alu_ng, instr_done;
  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];
  int n_chk, n_pass, we_cnt;

  hack_cpu_control dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .alu_x(alu_x), .alu_y(alu_y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc), .instr_done(instr_done)
  );

  function automatic logic [15:0] alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : x;
    a = c[4] ? ~a : a;
    b = c[3] ? 16'h0 : y;
    b = c[2] ? ~b : b;
    o = c[1] ? a + b : a & b;
    return c[0] ? ~o : o;
  endfunction

  assign alu_out = alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
  assign alu_zr = (alu_out == 16'h0);
  assign alu_ng = alu_out[15];

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    rom_data <= rom[rom_addr];
  end

  always @(negedge clk) if (ram_we) we_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; we_cnt = 0;
    for (int i = 0; i < 32768; i++) begin rom[i] = 16'h0; ram[i] = 16'h0; end
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
    rom[4] = 16'h0007; rom[5] = 16'hFDE8; rom[6] = 16'h0028; rom[7] = 16'hEA90;
    rom[8] = 16'hE301; rom[9] = 16'hEA87; rom[40] = 16'h7FFF; rom[41] = 16'hEA87;
    rom[32767] = 16'h0003;
    ram[7] = 16'h0009; ram[3] = 16'h1234;
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_pc", pc, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_a", ram_addr, 0);
    chk("rst_d", alu_x, 0);
    chk("rst_ctl", {zx, nx, zy, ny, f, no}, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_we", ram_we, 0);
    tick();
    chk("ainst_done", instr_done, 1);
    tick();
    chk("ainst_pc", pc, 1);
    chk("ainst_a", ram_addr, 5);
    chk("ainst_done_off", instr_done, 0);
    tick();
    chk("dA_dec_done", instr_done, 0);
    tick();
    chk("dA_ctl", {zx, nx, zy, ny, f, no}, 6'b110000);
    chk("dA_y", alu_y, 5);
    chk("dA_we", ram_we, 0);
    chk("dA_done", instr_done, 1);
    tick();
    chk("dA_pc", pc, 2);
    chk("dA_d", alu_x, 5);
    tick(); tick();
    chk("a100_pc", pc, 3);
    tick(); tick();
    chk("mD1_we", ram_we, 1);
    chk("mD1_addr", ram_addr, 100);
    chk("mD1_wdata", ram_wdata, 6);
    tick();
    chk("mD1_ram", ram[100], 6);
    chk("mD1_a", ram_addr, 100);
    chk("mD1_d", alu_x, 5);
    chk("mD1_pc", pc, 4);
    chk("mD1_wecnt", we_cnt, 1);
    tick(); tick(); tick(); tick();
    chk("amM1_y", alu_y, 9);
    chk("amM1_we", ram_we, 1);
    chk("amM1_addr", ram_addr, 7);
    chk("amM1_wdata", ram_wdata, 10);
    tick();
    chk("amM1_a", ram_addr, 10);
    chk("amM1_ram", ram[7], 10);
    chk("amM1_pc", pc, 6);
    tick(); tick();
    tick(); tick(); tick();
    chk("d0_d", alu_x, 0);
    chk("d0_pc", pc, 8);
    tick(); tick(); tick();
    chk("jgt_nt_pc", pc, 9);
    tick(); tick(); tick();
    chk("jmp_pc", pc, 40);
    tick(); tick();
    tick(); tick(); tick();
    chk("jmp_max_pc", pc, 15'h7FFF);
    tick(); tick();
    chk("wrap_pc", pc, 0);
    chk("wrap_a", ram_addr, 3);
    chk("wecnt2", we_cnt, 2);
    rom[0] = 16'hE308;
    tick(); tick();
    reset = 1;
    #1;
    chk("abort_we", ram_we, 0);
    chk("abort_done", instr_done, 0);
    tick();
    reset = 0;
    chk("abort_pc", pc, 0);
    chk("abort_a", ram_addr, 0);
    chk("abort_d", alu_x, 0);
    chk("abort_ram", ram[3], 16'h1234);
    chk("abort_wecnt", we_cnt, 2);
    tick();
    chk("refetch_dec_done", instr_done, 0);
    tick();
    chk("refetch_we", ram_we, 1);
    chk("refetch_addr", ram_addr, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
